// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the core's single-cycle load/store into a valid/ready bus
// transaction (IDLE -> ADDR -> DATA -> DONE) and holds the pipeline with stall.
// Optional build macro DMEM_MISALIGN_CHECK_EN: misaligned half/word requests
// skip the bus and finish with a one-cycle misalign flag.
module dmem_bridge #(
   parameter int TIMEOUT = 256,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              bus_err,
   output logic              misalign,
   output logic              bus_valid,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_write,
   output logic [3:0]        bus_strobe,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ready,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            state, nxt;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_write, cmd_uns;
   logic [1:0]        cmd_size;
   logic [31:0]       cmd_wdata;
   logic              err_q;
   logic              timed_out, timeout_hit, mis_hit;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_ext;

   // size 3 decodes as word, same as size 2
   wire cmd_byte = (cmd_size == 2'd0);
   wire cmd_half = (cmd_size == 2'd1);

`ifdef DMEM_MISALIGN_CHECK_EN
   logic mis_q;
   // half needs addr[0]=0, word needs addr[1:0]=0; byte is always aligned
   assign mis_hit  = ((req_size == 2'd1) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
   assign misalign = mis_q;
`else
   assign mis_hit  = 1'b0;
   assign misalign = 1'b0;
`endif

   // no-progress limit; TIMEOUT=0 never expires
   assign timed_out   = (TIMEOUT != 0) && (cnt == CNT_LAST);
   assign timeout_hit = timed_out && (((state == ADDR) && !bus_ready) ||
                                      ((state == DATA) && !bus_rvalid));

   assign stall     = req_valid && (state != DONE);
   assign bus_valid = (state == ADDR);
   assign bus_addr  = {cmd_addr[ADDR_W-1:2], 2'b00};
   assign bus_write = cmd_write;
   assign bus_err   = err_q;

   // store lane steering: strobes and replicated write data
   always_comb begin
      bus_strobe = 4'b0000;
      bus_wdata  = cmd_wdata;
      if (cmd_byte) begin
         bus_wdata = {4{cmd_wdata[7:0]}};
         if (cmd_write) bus_strobe = 4'b0001 << cmd_addr[1:0];
      end else if (cmd_half) begin
         bus_wdata = {2{cmd_wdata[15:0]}};
         if (cmd_write) bus_strobe = cmd_addr[1] ? 4'b1100 : 4'b0011;
      end else begin
         if (cmd_write) bus_strobe = 4'b1111;
      end
   end

   // load lane extraction and sign/zero extension
   always_comb begin
      ld_byte = bus_rdata[{cmd_addr[1:0], 3'b000} +: 8];
      ld_half = cmd_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      if (cmd_byte)      ld_ext = {{24{~cmd_uns & ld_byte[7]}}, ld_byte};
      else if (cmd_half) ld_ext = {{16{~cmd_uns & ld_half[15]}}, ld_half};
      else               ld_ext = bus_rdata;
   end

   // next-state: progress wins over timeout in the same cycle
   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (req_valid) nxt = mis_hit ? DONE : ADDR;
         ADDR: if (bus_ready) nxt = DATA;
               else if (timed_out) nxt = DONE;
         DATA: if (bus_rvalid || timed_out) nxt = DONE;
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // state register and wait counter (cleared on every state change)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if ((nxt != state) || ((state != ADDR) && (state != DATA))) cnt <= '0;
         else cnt <= cnt + CW'(1);
      end
   end

   // command registers captured when a request is accepted in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_addr  <= '0;
         cmd_write <= 1'b0;
         cmd_size  <= 2'd0;
         cmd_uns   <= 1'b0;
         cmd_wdata <= '0;
      end else if ((state == IDLE) && req_valid) begin
         cmd_addr  <= req_addr;
         cmd_write <= req_write;
         cmd_size  <= req_size;
         cmd_uns   <= req_unsigned;
         cmd_wdata <= req_wdata;
      end
   end

   // load result, timeout error and misalign flags for the DONE cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= timeout_hit;
         if (timeout_hit) rdata <= '0;
         else if ((state == DATA) && bus_rvalid && !cmd_write) rdata <= ld_ext;
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   // misalign flag lives only in the DONE cycle that follows the rejected request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mis_q <= 1'b0;
      else       mis_q <= (state == IDLE) && req_valid && mis_hit;
   end
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge (TIMEOUT=4): loads, stores, back-to-back,
// timeout, reset mid-transaction and the misalign option.
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stall, bus_err, misalign, bus_valid, bus_write;
   logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_strobe;
   logic        bus_ready, bus_rvalid;

   int total = 0;
   int bad   = 0;

   logic [31:0] o_addr, o_wdata, o_rdata;
   logic [3:0]  o_strb;
   logic        o_write, o_err, o_mis, o_done;
   int          n_stall, n_valid, n_gap;

   always #5 clk = ~clk;

   dmem_bridge #(.TIMEOUT(4), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata(rdata), .bus_err(bus_err), .misalign(misalign),
      .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_write(bus_write),
      .bus_strobe(bus_strobe), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one request and plays the bus side; rdy_dly = ADDR cycles before
   // bus_ready. Stops at the first stall-low cycle after the request stalled.
   task automatic run_access(input logic w, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int rdy_dly, input logic [31:0] rd);
      logic acc;
      acc = 1'b0;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      n_stall = 0; n_valid = 0; n_gap = 0; o_done = 1'b0;
      o_addr = '0; o_strb = '0; o_wdata = '0; o_write = 1'b0;
      o_rdata = '0; o_err = 1'b0; o_mis = 1'b0;
      #1;
      for (int i = 0; i < 30; i++) begin
         if (!stall) begin
            if (n_stall == 0) begin
               n_gap++;
               tick;
               continue;
            end
            o_done = 1'b1; o_rdata = rdata; o_err = bus_err; o_mis = misalign;
            break;
         end
         n_stall++;
         bus_ready = 1'b0; bus_rvalid = 1'b0;
         if (bus_valid) begin
            n_valid++;
            o_addr = bus_addr; o_strb = bus_strobe; o_wdata = bus_wdata; o_write = bus_write;
            if (n_valid > rdy_dly) begin bus_ready = 1'b1; acc = 1'b1; end
         end else if (acc) begin
            bus_rvalid = 1'b1; bus_rdata = rd;
         end
         tick;
      end
      bus_ready = 1'b0; bus_rvalid = 1'b0;
   endtask

   task automatic end_req;
      req_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
      bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
      tick; tick;
      reset = 1'b0;
      #1;
      total++; if (stall !== 1'b0)     begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
      total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus_valid); end
      total++; if (rdata !== 32'h0)    begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
      total++; if (bus_err !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b want=0", bus_err); end
      total++; if (misalign !== 1'b0)  begin bad++; $display("FAIL rst_mis got=%b want=0", misalign); end
      tick;
   endtask

   task automatic test_word_load;
      run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
      total++; if (o_done !== 1'b1)       begin bad++; $display("FAIL wl_done got=%b want=1", o_done); end
      total++; if (o_addr !== 32'h100)    begin bad++; $display("FAIL wl_addr got=%h want=00000100", o_addr); end
      total++; if (o_strb !== 4'b0000)    begin bad++; $display("FAIL wl_strb got=%b want=0000", o_strb); end
      total++; if (o_write !== 1'b0)      begin bad++; $display("FAIL wl_write got=%b want=0", o_write); end
      total++; if (n_stall != 5)          begin bad++; $display("FAIL wl_stall got=%0d want=5", n_stall); end
      total++; if (n_valid != 3)          begin bad++; $display("FAIL wl_valid got=%0d want=3", n_valid); end
      total++; if (o_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wl_rdata got=%h want=deadbeef", o_rdata); end
      total++; if (o_err !== 1'b0)        begin bad++; $display("FAIL wl_err got=%b want=0", o_err); end
      end_req;
      total++; if (stall !== 1'b0 || bus_valid !== 1'b0) begin bad++; $display("FAIL wl_idle got=%b%b want=00", stall, bus_valid); end
   endtask

   task automatic test_byte_half_load;
      run_access(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 0, 32'h80112233);
      total++; if (o_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_s got=%h want=ffffff80", o_rdata); end
      total++; if (n_stall != 3)             begin bad++; $display("FAIL lb_stall got=%0d want=3", n_stall); end
      total++; if (o_addr !== 32'h200)       begin bad++; $display("FAIL lb_addr got=%h want=00000200", o_addr); end
      end_req;
      run_access(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 0, 32'h80112233);
      total++; if (o_rdata !== 32'h00000080) begin bad++; $display("FAIL lb_u got=%h want=00000080", o_rdata); end
      end_req;
      run_access(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 0, 32'h80112233);
      total++; if (o_rdata !== 32'hFFFF8011) begin bad++; $display("FAIL lh_s got=%h want=ffff8011", o_rdata); end
      end_req;
      run_access(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 1, 32'h80112233);
      total++; if (o_rdata !== 32'h00000022) begin bad++; $display("FAIL lb_1 got=%h want=00000022", o_rdata); end
      end_req;
   endtask

   task automatic test_store;
      run_access(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000ABCD, 1, 32'h99999999);
      total++; if (o_done !== 1'b1)          begin bad++; $display("FAIL sh_done got=%b want=1", o_done); end
      total++; if (o_addr !== 32'h300)       begin bad++; $display("FAIL sh_addr got=%h want=00000300", o_addr); end
      total++; if (o_strb !== 4'b1100)       begin bad++; $display("FAIL sh_strb got=%b want=1100", o_strb); end
      total++; if (o_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h want=abcdabcd", o_wdata); end
      total++; if (o_write !== 1'b1)         begin bad++; $display("FAIL sh_write got=%b want=1", o_write); end
      total++; if (o_rdata !== 32'h00000022) begin bad++; $display("FAIL sh_rdata got=%h want=00000022", o_rdata); end
      end_req;
      run_access(1'b1, 2'd0, 1'b0, 32'h301, 32'h1234565A, 0, 32'h0);
      total++; if (o_strb !== 4'b0010)       begin bad++; $display("FAIL sb_strb got=%b want=0010", o_strb); end
      total++; if (o_wdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL sb_wdata got=%h want=5a5a5a5a", o_wdata); end
      end_req;
      run_access(1'b1, 2'd3, 1'b0, 32'h400, 32'h11223344, 0, 32'h0);
      total++; if (o_strb !== 4'b1111)       begin bad++; $display("FAIL sw_strb got=%b want=1111", o_strb); end
      total++; if (o_wdata !== 32'h11223344) begin bad++; $display("FAIL sw_wdata got=%h want=11223344", o_wdata); end
      end_req;
   endtask

   task automatic test_back_to_back;
      int extra;
      run_access(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 0, 32'h11111111);
      total++; if (n_gap != 0 || n_valid != 1) begin bad++; $display("FAIL b2b_first gap=%0d valid=%0d want 0/1", n_gap, n_valid); end
      total++; if (o_rdata !== 32'h11111111)   begin bad++; $display("FAIL b2b_rd0 got=%h want=11111111", o_rdata); end
      run_access(1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 0, 32'h22222222);
      total++; if (n_gap != 1)                 begin bad++; $display("FAIL b2b_gap got=%0d want=1", n_gap); end
      total++; if (n_valid != 1)               begin bad++; $display("FAIL b2b_valid got=%0d want=1", n_valid); end
      total++; if (n_stall != 3)               begin bad++; $display("FAIL b2b_stall got=%0d want=3", n_stall); end
      total++; if (o_addr !== 32'h504)         begin bad++; $display("FAIL b2b_addr got=%h want=00000504", o_addr); end
      total++; if (o_rdata !== 32'h22222222)   begin bad++; $display("FAIL b2b_rd1 got=%h want=22222222", o_rdata); end
      end_req;
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus_valid) extra++;
         tick;
      end
      total++; if (extra != 0) begin bad++; $display("FAIL b2b_dup got=%0d want=0", extra); end
   endtask

   task automatic test_timeout;
      run_access(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 99, 32'h0);
      total++; if (o_done !== 1'b1)  begin bad++; $display("FAIL to_done got=%b want=1", o_done); end
      total++; if (n_valid != 4)     begin bad++; $display("FAIL to_addr_cycles got=%0d want=4", n_valid); end
      total++; if (n_stall != 5)     begin bad++; $display("FAIL to_stall got=%0d want=5", n_stall); end
      total++; if (o_err !== 1'b1)   begin bad++; $display("FAIL to_err got=%b want=1", o_err); end
      total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h want=0", o_rdata); end
      end_req;
      total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b want=0", bus_err); end
   endtask

   task automatic test_reset_in_data;
      run_access(1'b0, 2'd2, 1'b0, 32'h700, 32'h0, 0, 32'h0BADF00D);
      end_req;
      total++; if (rdata !== 32'h0BADF00D) begin bad++; $display("FAIL rd_pre got=%h want=0badf00d", rdata); end
      req_valid = 1; req_write = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h704;
      tick;
      total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL rd_addr_valid got=%b want=1", bus_valid); end
      bus_ready = 1;
      tick;
      bus_ready = 0;
      #2 reset = 1'b1;
      #1;
      total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL rd_async_valid got=%b want=0", bus_valid); end
      total++; if (rdata !== 32'h0)    begin bad++; $display("FAIL rd_async_rdata got=%h want=0", rdata); end
      req_valid = 0;
      tick;
      reset = 1'b0;
      bus_rvalid = 1; bus_rdata = 32'h12345678;
      tick;
      bus_rvalid = 0;
      total++; if (rdata !== 32'h0)    begin bad++; $display("FAIL rd_stale got=%h want=0", rdata); end
      total++; if (stall !== 1'b0 || bus_valid !== 1'b0) begin bad++; $display("FAIL rd_idle got=%b%b want=00", stall, bus_valid); end
      run_access(1'b0, 2'd2, 1'b0, 32'h708, 32'h0, 0, 32'h5555AAAA);
      total++; if (o_rdata !== 32'h5555AAAA || n_stall != 3) begin bad++; $display("FAIL rd_recover got=%h/%0d want=5555aaaa/3", o_rdata, n_stall); end
      end_req;
   endtask

   task automatic test_misalign;
      run_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'hCAFEF00D);
`ifdef DMEM_MISALIGN_CHECK_EN
      total++; if (n_valid != 0)          begin bad++; $display("FAIL mis_valid got=%0d want=0", n_valid); end
      total++; if (n_stall != 1)          begin bad++; $display("FAIL mis_stall got=%0d want=1", n_stall); end
      total++; if (o_mis !== 1'b1)        begin bad++; $display("FAIL mis_flag got=%b want=1", o_mis); end
      total++; if (o_rdata !== 32'h5555AAAA) begin bad++; $display("FAIL mis_rdata got=%h want=5555aaaa", o_rdata); end
      end_req;
      total++; if (misalign !== 1'b0)     begin bad++; $display("FAIL mis_pulse got=%b want=0", misalign); end
`else
      total++; if (n_valid != 1)          begin bad++; $display("FAIL mis_valid got=%0d want=1", n_valid); end
      total++; if (o_addr !== 32'h100)    begin bad++; $display("FAIL mis_addr got=%h want=00000100", o_addr); end
      total++; if (o_mis !== 1'b0)        begin bad++; $display("FAIL mis_flag got=%b want=0", o_mis); end
      total++; if (o_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_rdata got=%h want=cafef00d", o_rdata); end
      end_req;
      run_access(1'b0, 2'd1, 1'b1, 32'h203, 32'h0, 0, 32'h80112233);
      total++; if (o_rdata !== 32'h00008011) begin bad++; $display("FAIL mis_half got=%h want=00008011", o_rdata); end
      end_req;
`endif
   endtask

   initial begin
      test_reset;
      test_word_load;
      test_byte_half_load;
      test_store;
      test_back_to_back;
      test_timeout;
      test_reset_in_data;
      test_misalign;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
